// File: rtl/mcu_spi_pkg.sv
// ============================================================================
// Module  : mcu_spi_pkg
// Brief   : Shared constants for the IMU telemetry SPI slave packet layout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mcu_spi_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hAA;
  localparam int         PKT_BYTES   = 16;

  // Bit positions inside the flags byte
  localparam int FLAG_QUAT   = 0;
  localparam int FLAG_GYRO   = 1;
  localparam int FLAG_NOINIT = 2;
  localparam int FLAG_ERR    = 3;

  // Byte offsets of each field; 16-bit words occupy offset (MSB) and offset+1 (LSB)
  localparam int PKT_HDR    = 0;
  localparam int PKT_QUAT_W = 1;
  localparam int PKT_QUAT_X = 3;
  localparam int PKT_QUAT_Y = 5;
  localparam int PKT_QUAT_Z = 7;
  localparam int PKT_GYRO_X = 9;
  localparam int PKT_GYRO_Y = 11;
  localparam int PKT_GYRO_Z = 13;
  localparam int PKT_FLAGS  = 15;

  localparam logic [6:0] LAST_BIT = 7'd127;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// Module  : spi_sync_edge
// Brief   : Multi-flop synchronizer with single-cycle rise/fall pulses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  // STAGES must be at least 2 for the shift below
  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], din};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign dout = r_sync[STAGES-1];
  assign rise = r_sync[STAGES-1] & ~r_prev;
  assign fall = ~r_sync[STAGES-1] & r_prev;

endmodule

`default_nettype wire

// File: rtl/mcu_spi_slave.sv
// ============================================================================
// Module  : mcu_spi_slave
// Brief   : SPI mode-0 slave streaming a 16-byte IMU telemetry packet, MSB first.
//           Optional PKT_SEQ_EN adds a 4-bit frame sequence counter in flags[7:4].
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mcu_spi_slave #(
  parameter logic [7:0] HEADER_BYTE = mcu_spi_pkg::HEADER_BYTE,
  parameter int         PKT_BYTES   = mcu_spi_pkg::PKT_BYTES,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        sdi,
  output logic        sdo,
  input  logic        cs_n,
  input  logic        initialized,
  input  logic        error,
  input  logic        quat1_valid,
  input  logic [15:0] quat1_w,
  input  logic [15:0] quat1_x,
  input  logic [15:0] quat1_y,
  input  logic [15:0] quat1_z,
  input  logic        gyro1_valid,
  input  logic [15:0] gyro1_x,
  input  logic [15:0] gyro1_y,
  input  logic [15:0] gyro1_z
);

  import mcu_spi_pkg::*;

  logic [7:0] packet_buffer [0:PKT_BYTES-1];
  logic [6:0] bit_cnt;
  logic [6:0] w_bit_cnt_nxt;
  logic       r_frozen;
  logic       r_sdo;
  logic [7:0] w_flags;
  logic       w_frame_done;

  logic w_sck_s, w_sck_rise, w_sck_fall;
  logic w_cs_s, w_cs_rise, w_cs_fall;
  logic w_sdi_s, w_sdi_rise, w_sdi_fall;
  logic w_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst_n(rst_n), .din(sck),
    .dout(w_sck_s), .rise(w_sck_rise), .fall(w_sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .din(cs_n),
    .dout(w_cs_s), .rise(w_cs_rise), .fall(w_cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sdi_sync (
    .clk(clk), .rst_n(rst_n), .din(sdi),
    .dout(w_sdi_s), .rise(w_sdi_rise), .fall(w_sdi_fall)
  );

  // The slave never receives data; synchronized MOSI is deliberately dropped
  assign w_unused = ^{w_sck_s, w_sdi_s, w_sdi_rise, w_sdi_fall};

  // A cs_n rise on the same cycle as an sck fall is never counted as a bit
  assign w_frame_done = !w_cs_s && !w_cs_fall && w_sck_fall && (bit_cnt == LAST_BIT);

  always_comb begin
    w_bit_cnt_nxt = bit_cnt;
    if (w_cs_rise || w_cs_fall) begin
      w_bit_cnt_nxt = 7'd0;
    end else if (!w_cs_s && w_sck_fall) begin
      w_bit_cnt_nxt = bit_cnt + 7'd1;
    end
  end

`ifdef PKT_SEQ_EN
  logic [3:0] r_seq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq <= 4'h0;
    end else if (w_frame_done) begin
      r_seq <= r_seq + 4'h1;
    end
  end
`endif

  always_comb begin
    w_flags              = 8'h00;
    w_flags[FLAG_QUAT]   = quat1_valid;
    w_flags[FLAG_GYRO]   = gyro1_valid;
    w_flags[FLAG_NOINIT] = ~initialized;
    w_flags[FLAG_ERR]    = error;
`ifdef PKT_SEQ_EN
    w_flags[7:4]         = r_seq;
`endif
  end

  // Frame tracking: frozen from the first sck rise until abort or bit 127 completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= 7'd0;
      r_frozen <= 1'b0;
      r_sdo    <= 1'b0;
    end else begin
      bit_cnt <= w_bit_cnt_nxt;
      r_sdo   <= packet_buffer[w_bit_cnt_nxt[6:3]][3'd7 - w_bit_cnt_nxt[2:0]];
      if (w_cs_rise || w_cs_fall || w_cs_s || w_frame_done) begin
        r_frozen <= 1'b0;
      end else if (w_sck_rise) begin
        r_frozen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PKT_BYTES; i++) begin
        packet_buffer[i] <= 8'h00;
      end
    end else if (!r_frozen) begin
      packet_buffer[PKT_HDR] <= HEADER_BYTE;
      {packet_buffer[PKT_QUAT_W], packet_buffer[PKT_QUAT_W+1]} <= quat1_w;
      {packet_buffer[PKT_QUAT_X], packet_buffer[PKT_QUAT_X+1]} <= quat1_x;
      {packet_buffer[PKT_QUAT_Y], packet_buffer[PKT_QUAT_Y+1]} <= quat1_y;
      {packet_buffer[PKT_QUAT_Z], packet_buffer[PKT_QUAT_Z+1]} <= quat1_z;
      {packet_buffer[PKT_GYRO_X], packet_buffer[PKT_GYRO_X+1]} <= gyro1_x;
      {packet_buffer[PKT_GYRO_Y], packet_buffer[PKT_GYRO_Y+1]} <= gyro1_y;
      {packet_buffer[PKT_GYRO_Z], packet_buffer[PKT_GYRO_Z+1]} <= gyro1_z;
      packet_buffer[PKT_FLAGS] <= w_flags;
    end
  end

  assign sdo = r_sdo;

endmodule

`default_nettype wire

// File: tb/tb_mcu_spi_slave.sv
// ============================================================================
// Module  : tb_mcu_spi_slave
// Brief   : Randomized self-checking bench for mcu_spi_slave against a packet model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcu_spi_slave;

  logic        clk = 1'b0;
  logic        rst_n, sck, sdi, sdo, cs_n;
  logic        initialized, error, quat1_valid, gyro1_valid;
  logic [15:0] qw, qx, qy, qz, gx, gy, gz;

  int vectors     = 0;
  int miscompares = 0;
  int frames_done = 0;

  logic [7:0] exp_buf [0:15];
  logic [7:0] snap    [0:15];

  mcu_spi_slave dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .sdi(sdi), .sdo(sdo), .cs_n(cs_n),
    .initialized(initialized), .error(error),
    .quat1_valid(quat1_valid), .quat1_w(qw), .quat1_x(qx), .quat1_y(qy), .quat1_z(qz),
    .gyro1_valid(gyro1_valid), .gyro1_x(gx), .gyro1_y(gy), .gyro1_z(gz)
  );

  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Packet as the MCU should see it, built straight from the field list
  task automatic model();
    logic [15:0] w [7];
    logic [3:0]  seq;
    w[0] = qw; w[1] = qx; w[2] = qy; w[3] = qz; w[4] = gx; w[5] = gy; w[6] = gz;
`ifdef PKT_SEQ_EN
    seq = 4'(frames_done % 16);
`else
    seq = 4'h0;
`endif
    exp_buf[0] = 8'hAA;
    for (int k = 0; k < 7; k++) begin
      exp_buf[2*k+1] = w[k][15:8];
      exp_buf[2*k+2] = w[k][7:0];
    end
    exp_buf[15] = {seq, error, ~initialized, gyro1_valid, quat1_valid};
  endtask

  task automatic randomize_inputs();
    qw = 16'($urandom); qx = 16'($urandom); qy = 16'($urandom); qz = 16'($urandom);
    gx = 16'($urandom); gy = 16'($urandom); gz = 16'($urandom);
    initialized = 1'($urandom_range(0, 1));
    error       = 1'($urandom_range(0, 1));
    quat1_valid = 1'($urandom_range(0, 1));
    gyro1_valid = 1'($urandom_range(0, 1));
  endtask

  // Clocks nbits mode-0 bits; sdo is sampled just before each sck rise
  task automatic shift_bits(input int nbits, input int change_at, input string tag);
    logic [7:0] b;
    model();
    for (int i = 0; i < 16; i++) snap[i] = exp_buf[i];
    for (int i = 0; i < nbits; i++) begin
      b = snap[i/8];
      vectors++;
      if (sdo !== b[7 - (i % 8)]) begin
        miscompares++;
        $display("FAIL %s bit %0d: sdo=%b expected %b", tag, i, sdo, b[7 - (i % 8)]);
      end
      sdi = 1'($urandom_range(0, 1));
      sck = 1'b1;
      wait_clk(4);
      sck = 1'b0;
      if (i == change_at) randomize_inputs();
      wait_clk(4);
      if (i == change_at + 2) begin
        for (int k = 0; k < 16; k++) begin
          vectors++;
          if (dut.packet_buffer[k] !== snap[k]) begin
            miscompares++;
            $display("FAIL %s frozen byte %0d: got %02h expected %02h",
                     tag, k, dut.packet_buffer[k], snap[k]);
          end
        end
      end
    end
    if (nbits == 128) frames_done++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs_n = 1'b1; sck = 1'b0; sdi = 1'b0;
    initialized = 1'b0; error = 1'b0; quat1_valid = 1'b0; gyro1_valid = 1'b0;
    qw = 16'h0; qx = 16'h0; qy = 16'h0; qz = 16'h0; gx = 16'h0; gy = 16'h0; gz = 16'h0;
    wait_clk(3);
    vectors++;
    if (dut.packet_buffer[0] !== 8'h00 || dut.packet_buffer[15] !== 8'h00 || sdo !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: buf0=%02h buf15=%02h sdo=%b expected 00 00 0",
               dut.packet_buffer[0], dut.packet_buffer[15], sdo);
    end
    rst_n = 1'b1;
    wait_clk(1);
    vectors++;
    if (dut.packet_buffer[0] !== 8'hAA) begin
      miscompares++;
      $display("FAIL reset_header: buf0=%02h expected aa", dut.packet_buffer[0]);
    end
    wait_clk(2);
    vectors++;
    if (sdo !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_sdo: sdo=%b expected 1", sdo);
    end
  endtask

  task automatic test_live();
    cs_n = 1'b0;
    wait_clk(4);
    for (int v = 0; v < 20; v++) begin
      randomize_inputs();
      case (v)
        0: begin qw = 16'h1234; qx = 16'h5678; qy = 16'h9ABC; qz = 16'hDEF0; end
        1: qw = 16'h7FFF;
        2: qw = 16'h8000;
        3: qw = 16'hFFFF;
        4: qw = 16'h0000;
        5, 6, 7: begin
          gx = 16'h1111; gy = 16'h2222; gz = 16'h3333;
          initialized = 1'b1; error = 1'b0;
          quat1_valid = (v != 6);
          gyro1_valid = (v != 5);
        end
        8: begin initialized = 1'b0; error = 1'b1; end
        default: ;
      endcase
      wait_clk(2);
      model();
      for (int k = 0; k < 16; k++) begin
        vectors++;
        if (dut.packet_buffer[k] !== exp_buf[k]) begin
          miscompares++;
          $display("FAIL live v%0d byte %0d: got %02h expected %02h",
                   v, k, dut.packet_buffer[k], exp_buf[k]);
        end
      end
      vectors++;
      if (sdo !== 1'b1) begin
        miscompares++;
        $display("FAIL live_sdo v%0d: sdo=%b expected 1", v, sdo);
      end
    end
  endtask

  task automatic test_frame();
    for (int f = 0; f < 2; f++) begin
      cs_n = 1'b0;
      randomize_inputs();
      wait_clk(4);
      shift_bits(128, 40 + f * 30, "frame");
      model();
      for (int k = 0; k < 16; k++) begin
        vectors++;
        if (dut.packet_buffer[k] !== exp_buf[k]) begin
          miscompares++;
          $display("FAIL frame_relive f%0d byte %0d: got %02h expected %02h",
                   f, k, dut.packet_buffer[k], exp_buf[k]);
        end
      end
      vectors++;
      if (sdo !== 1'b1) begin
        miscompares++;
        $display("FAIL frame_wrap_sdo f%0d: sdo=%b expected 1", f, sdo);
      end
      cs_n = 1'b1;
      wait_clk(6);
    end
  endtask

  task automatic test_abort();
    cs_n = 1'b0;
    randomize_inputs();
    wait_clk(4);
    shift_bits(20, -1, "abort_pre");
    cs_n = 1'b1;
    wait_clk(4);
    randomize_inputs();
    cs_n = 1'b0;
    wait_clk(4);
    vectors++;
    if (dut.bit_cnt !== 7'd0) begin
      miscompares++;
      $display("FAIL abort_bitcnt: bit_cnt=%0d expected 0", dut.bit_cnt);
    end
    shift_bits(16, -1, "abort_restart");
    cs_n = 1'b1;
    wait_clk(4);
    model();
    vectors++;
    if (dut.packet_buffer[15] !== exp_buf[15] || dut.packet_buffer[1] !== exp_buf[1]) begin
      miscompares++;
      $display("FAIL abort_relive: flags=%02h b1=%02h expected %02h %02h",
               dut.packet_buffer[15], dut.packet_buffer[1], exp_buf[15], exp_buf[1]);
    end
  endtask

  task automatic test_back_to_back();
    cs_n = 1'b0;
    randomize_inputs();
    initialized = 1'b0;
    error       = 1'b1;
    wait_clk(4);
    for (int f = 0; f < 3; f++) shift_bits(128, -1, "b2b");
    model();
    vectors++;
    if (dut.packet_buffer[15] !== exp_buf[15]) begin
      miscompares++;
      $display("FAIL b2b_flags: got %02h expected %02h", dut.packet_buffer[15], exp_buf[15]);
    end
    vectors++;
    if (dut.packet_buffer[15][3:2] !== 2'b11) begin
      miscompares++;
      $display("FAIL noinit_err_bits: got %b expected 11", dut.packet_buffer[15][3:2]);
    end
    cs_n = 1'b1;
    wait_clk(4);
  endtask

  initial begin
    test_reset();
    test_live();
    test_frame();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
